// File: rtl/tdc_hit_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// tdc_hit_capture_ctrl_if
// Event handshake bundle between the TDC hit-capture sequencer and readout.
//   out_valid  : event available (driven by the sequencer)
//   out_ready  : readout accepts the event this cycle (driven by readout)
//   out_fine   : popcount of the captured thermometer word
//   out_coarse : coarse timestamp of the detection cycle
//   out_bubble : captured word was not a pure thermometer code
//   out_ovf    : captured word was all ones
// Modports: master = sequencer side, slave = readout side.
// ---------------------------------------------------------------------------
interface tdc_hit_capture_ctrl_if #(
    parameter int FW       = 8,
    parameter int COARSE_W = 32
);
    logic                out_valid;
    logic                out_ready;
    logic [FW-1:0]       out_fine;
    logic [COARSE_W-1:0] out_coarse;
    logic                out_bubble;
    logic                out_ovf;

    modport master (
        output out_valid, out_fine, out_coarse, out_bubble, out_ovf,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_fine, out_coarse, out_bubble, out_ovf,
        output out_ready
    );
endinterface

// File: rtl/tdc_hit_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tdc_hit_capture_ctrl
// Sequencer for the TDC delay-line sampling pipeline. Detects a rising edge
// at tap 0 of the registered thermometer word, latches the word and the
// coarse timestamp, converts the word to a fine code and presents one event
// per hit over a valid/ready handshake. A programmable dead time follows each
// handshake, and hits arriving while busy are counted as lost.
// Ports:
//   clk      : system clock (shared with the sampling pipeline)
//   rst      : synchronous reset, active-high
//   arm_en   : 1 = accept hits, 0 = return to IDLE once the event is done
//   pipe_q   : registered thermometer word, bit0 = first tap
//   ev       : event handshake (master side of tdc_hit_capture_ctrl_if)
//   busy     : state is CONV, HOLD or DEAD
//   lost_cnt : saturating count of hits seen while CONV/HOLD/DEAD
// ---------------------------------------------------------------------------
module tdc_hit_capture_ctrl #(
    parameter int NFF         = 208,
    parameter int FW          = 8,
    parameter int COARSE_W    = 32,
    parameter int DEAD_CYCLES = 4,
    parameter int LOST_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm_en,
    input  logic [NFF-1:0]          pipe_q,
    tdc_hit_capture_ctrl_if.master  ev,
    output logic                    busy,
    output logic [LOST_W-1:0]       lost_cnt
);

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CONV,
        HOLD,
        DEAD
    } state_t;

    state_t              state;
    logic                prev0;
    logic [COARSE_W-1:0] coarse;
    logic [NFF-1:0]      word;
    logic [COARSE_W-1:0] ts;
    logic [DW-1:0]       dead_cnt;

    logic                valid_q;
    logic [FW-1:0]       fine_q;
    logic [COARSE_W-1:0] coarse_q;
    logic                bubble_q;
    logic                ovf_q;

    logic                hit;
    logic                in_event;
    logic [FW-1:0]       pop;
    logic                bubble_c;
    logic                ovf_c;

    assign hit      = pipe_q[0] & ~prev0;
    assign in_event = (state == CONV) || (state == HOLD) || (state == DEAD);
    assign busy     = in_event;

    assign ev.out_valid  = valid_q;
    assign ev.out_fine   = fine_q;
    assign ev.out_coarse = coarse_q;
    assign ev.out_bubble = bubble_q;
    assign ev.out_ovf    = ovf_q;

    // Fine code is the plain popcount so a bubbled word still yields a
    // sensible position. A pure thermometer word (2**k - 1) has no bit in
    // common with word+1; any overlap means a 1 sits above a 0.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NFF; i++) begin
            pop = pop + FW'(word[i]);
        end
        bubble_c = |(word & (word + NFF'(1)));
        ovf_c    = &word;
    end

    // Single sequential block: free-running coarse counter, tap-0 edge
    // register, lost-hit counter and the capture FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prev0    <= 1'b0;
            coarse   <= '0;
            word     <= '0;
            ts       <= '0;
            dead_cnt <= '0;
            valid_q  <= 1'b0;
            fine_q   <= '0;
            coarse_q <= '0;
            bubble_q <= 1'b0;
            ovf_q    <= 1'b0;
            lost_cnt <= '0;
        end else begin
            coarse <= coarse + COARSE_W'(1);
            prev0  <= pipe_q[0];

            // Hits during an event are lost; IDLE hits are simply ignored.
            if (hit && in_event && (lost_cnt != {LOST_W{1'b1}})) begin
                lost_cnt <= lost_cnt + LOST_W'(1);
            end

            case (state)
                IDLE: begin
                    if (arm_en) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    // Disarming wins over a simultaneous hit.
                    if (!arm_en) begin
                        state <= IDLE;
                    end else if (hit) begin
                        word  <= pipe_q;
                        ts    <= coarse;
                        state <= CONV;
                    end
                end
                CONV: begin
                    fine_q   <= pop;
                    coarse_q <= ts;
                    bubble_q <= bubble_c;
                    ovf_q    <= ovf_c;
                    valid_q  <= 1'b1;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (ev.out_ready) begin
                        valid_q  <= 1'b0;
                        dead_cnt <= '0;
                        state    <= DEAD;
                    end
                end
                DEAD: begin
                    if (dead_cnt == DW'(DEAD_CYCLES - 1)) begin
                        state <= arm_en ? ARMED : IDLE;
                    end else begin
                        dead_cnt <= dead_cnt + DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_hit_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tdc_hit_capture_ctrl
// Directed bench for the TDC hit-capture sequencer. Stimulus pushes the
// hand-computed expected event into a queue; a negedge monitor pops it when
// out_valid rises and checks fields, latency and stability until handshake.
// COARSE_W and LOST_W are reduced so counter wrap and lost-hit saturation
// are reachable in a short run.
// ---------------------------------------------------------------------------
module tb_tdc_hit_capture_ctrl;

    localparam int NFF         = 208;
    localparam int FW          = 8;
    localparam int COARSE_W    = 8;
    localparam int DEAD_CYCLES = 4;
    localparam int LOST_W      = 4;

    typedef struct {
        logic [FW-1:0]       fine;
        logic [COARSE_W-1:0] coarse;
        logic                bubble;
        logic                ovf;
        int                  rise;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                arm_en;
    logic [NFF-1:0]      pipe_q;
    logic                busy;
    logic [LOST_W-1:0]   lost_cnt;

    tdc_hit_capture_ctrl_if #(.FW(FW), .COARSE_W(COARSE_W)) bus ();

    tdc_hit_capture_ctrl #(
        .NFF(NFF), .FW(FW), .COARSE_W(COARSE_W),
        .DEAD_CYCLES(DEAD_CYCLES), .LOST_W(LOST_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arm_en   (arm_en),
        .pipe_q   (pipe_q),
        .ev       (bus),
        .busy     (busy),
        .lost_cnt (lost_cnt)
    );

    exp_t                q[$];
    exp_t                cur;
    int                  passed = 0;
    int                  total  = 0;
    int                  hs_count = 0;
    int                  exp_hs = 0;
    int                  cyc = 0;
    logic [COARSE_W-1:0] coarse_m = '0;
    logic                prev_valid = 1'b0;
    logic                hs_prev = 1'b0;

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index and a free-running coarse reference that restarts on rst.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        coarse_m <= rst ? '0 : coarse_m + 1'b1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [NFF-1:0] thermo(input int n);
        logic [NFF-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[i] = 1'b1;
        return w;
    endfunction

    // Drives a word onto pipe_q for one cycle (or leaves it if keep=1) and
    // queues the event it should produce.
    task automatic applyStimulus(input logic [NFF-1:0] w, input int fine, input logic bub,
                                 input logic ovf, input bit expect_ev, input bit keep);
        exp_t e;
        pipe_q = w;
        if (expect_ev) begin
            e.fine   = FW'(fine);
            e.coarse = coarse_m;
            e.bubble = bub;
            e.ovf    = ovf;
            e.rise   = cyc + 2;
            q.push_back(e);
            exp_hs++;
        end
        tick(1);
        if (!keep) pipe_q = '0;
    endtask

    task automatic pulse_tap0();
        pipe_q = thermo(1);
        tick(1);
        pipe_q = '0;
        tick(1);
    endtask

    task automatic wait_coarse(input logic [COARSE_W-1:0] target);
        int n;
        n = 0;
        while (coarse_m != target && n < 600) begin
            tick(1);
            n++;
        end
        checkOutput("wait_coarse_timeout", (coarse_m == target), 1);
    endtask

    // Monitor: pops the expected event on each valid rise, then checks the
    // event stays stable until handshake and that valid drops afterwards.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            hs_prev    = 1'b0;
        end else begin
            if (hs_prev) checkOutput("valid_drop", bus.out_valid, 0);
            hs_prev = 1'b0;
            if (bus.out_valid && !prev_valid) begin
                checkOutput("event_expected", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    cur = q.pop_front();
                    checkOutput("latency", cyc, cur.rise);
                    checkOutput("fine", bus.out_fine, cur.fine);
                    checkOutput("coarse", bus.out_coarse, cur.coarse);
                    checkOutput("bubble", bus.out_bubble, cur.bubble);
                    checkOutput("ovf", bus.out_ovf, cur.ovf);
                end
            end else if (bus.out_valid) begin
                checkOutput("stable_fine", bus.out_fine, cur.fine);
                checkOutput("stable_coarse", bus.out_coarse, cur.coarse);
                checkOutput("stable_flags", {bus.out_bubble, bus.out_ovf}, {cur.bubble, cur.ovf});
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_count++;
                hs_prev = 1'b1;
            end
            prev_valid = bus.out_valid;
        end
    end

    initial begin
        rst = 1'b1;
        arm_en = 1'b0;
        pipe_q = '0;
        bus.out_ready = 1'b1;
        tick(3);

        // Reset state
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_fine", bus.out_fine, 0);
        checkOutput("rst_coarse", bus.out_coarse, 0);
        checkOutput("rst_flags", {bus.out_bubble, bus.out_ovf}, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_lost", lost_cnt, 0);
        rst = 1'b0;
        arm_en = 1'b1;
        tick(2);

        // T1 basic capture, 37 taps
        applyStimulus(thermo(37), 37, 1'b0, 1'b0, 1, 0);
        tick(10);
        checkOutput("t1_busy", busy, 0);

        // T2 stall with out_ready low, then dead time of 4 cycles
        bus.out_ready = 1'b0;
        applyStimulus(thermo(37), 37, 1'b0, 1'b0, 1, 0);
        tick(6);
        checkOutput("t2_busy_hold", busy, 1);
        bus.out_ready = 1'b1;
        tick(1);
        tick(3);
        checkOutput("t2_busy_dead_last", busy, 1);
        tick(1);
        checkOutput("t2_armed", busy, 0);

        // T5a disarm in ARMED wins over a simultaneous hit; IDLE hits ignored
        arm_en = 1'b0;
        applyStimulus(thermo(3), 3, 1'b0, 1'b0, 0, 0);
        tick(3);
        pulse_tap0();
        tick(2);
        checkOutput("t5a_busy", busy, 0);
        checkOutput("t5a_lost", lost_cnt, 0);

        // Hit in the first ARMED cycle is captured
        arm_en = 1'b1;
        tick(1);
        applyStimulus(thermo(64), 64, 1'b0, 1'b0, 1, 0);
        tick(10);

        // T3 three lost hits (two in HOLD, one in DEAD)
        bus.out_ready = 1'b0;
        applyStimulus(thermo(5), 5, 1'b0, 1'b0, 1, 0);
        tick(1);
        pulse_tap0();
        pulse_tap0();
        bus.out_ready = 1'b1;
        tick(2);
        pulse_tap0();
        tick(2);
        checkOutput("t3_lost", lost_cnt, 3);
        checkOutput("t3_busy", busy, 0);

        // T3/T4 bubble word 0x0F0F held while lost_cnt saturates at 15
        bus.out_ready = 1'b0;
        applyStimulus({196'b0, 12'hF0F}, 8, 1'b1, 1'b0, 1, 0);
        tick(1);
        for (int i = 0; i < 12; i++) pulse_tap0();
        checkOutput("t3_lost_max", lost_cnt, 15);
        pulse_tap0();
        pulse_tap0();
        checkOutput("t3_lost_sat", lost_cnt, 15);
        bus.out_ready = 1'b1;
        tick(8);

        // T4 all-ones overflow and single-tap minimum
        applyStimulus({NFF{1'b1}}, 208, 1'b0, 1'b1, 1, 0);
        tick(10);
        applyStimulus(thermo(1), 1, 1'b0, 1'b0, 1, 0);
        tick(10);

        // T5b disarm during HOLD: event delivered, then IDLE (a hit coinciding
        // with re-arm must not be captured)
        bus.out_ready = 1'b0;
        applyStimulus(thermo(100), 100, 1'b0, 1'b0, 1, 0);
        tick(1);
        arm_en = 1'b0;
        tick(2);
        bus.out_ready = 1'b1;
        tick(5);
        checkOutput("t5b_busy", busy, 0);
        arm_en = 1'b1;
        applyStimulus(thermo(1), 1, 1'b0, 1'b0, 0, 0);
        tick(10);

        // T5c constant tap0 high gives exactly one event
        applyStimulus(thermo(10), 10, 1'b0, 1'b0, 1, 1);
        tick(30);
        pipe_q = '0;
        tick(2);

        // T6 reset during HOLD discards the event
        bus.out_ready = 1'b0;
        applyStimulus(thermo(20), 20, 1'b0, 1'b0, 1, 0);
        exp_hs--;
        tick(2);
        rst = 1'b1;
        tick(1);
        checkOutput("t6_valid", bus.out_valid, 0);
        checkOutput("t6_lost", lost_cnt, 0);
        checkOutput("t6_coarse", bus.out_coarse, 0);
        checkOutput("t6_busy", busy, 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick(1);
        applyStimulus(thermo(7), 7, 1'b0, 1'b0, 1, 0);
        tick(10);

        // T6 coarse wrap: hit at 247, then hit right after wrap stamps 0
        wait_coarse(8'd247);
        applyStimulus(thermo(200), 200, 1'b0, 1'b0, 1, 0);
        wait_coarse(8'd0);
        applyStimulus(thermo(150), 150, 1'b0, 1'b0, 1, 0);
        tick(12);

        checkOutput("queue_drained", q.size(), 0);
        checkOutput("handshakes", hs_count, exp_hs);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
